// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and constant helpers for the dividers
package div_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

    function automatic logic [MAX_W-1:0] min_s(input int w);
        return {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
    endfunction

    function automatic logic [MAX_W-1:0] all_ones(input int w);
        return {MAX_W{1'b1}} >> (MAX_W - w);
    endfunction

    // Divide-by-zero sentinel: quotient is all ones, remainder echoes the dividend.
    function automatic logic [MAX_W-1:0] dbz_quotient(input int w);
        return all_ones(w);
    endfunction

endpackage

// File: rtl/div_radix4_step.sv
// rtl/div_radix4_step.sv - one radix-4 restoring iteration
module div_radix4_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH+1:0] r,
    input  logic [WIDTH+1:0] d,
    input  logic [WIDTH+1:0] d2,
    input  logic [WIDTH+1:0] d3,
    input  logic [1:0]       bits,
    output logic [WIDTH+1:0] r_next,
    output logic [1:0]       q_digit
);

    logic [WIDTH+1:0] r_sh;

    // The incoming r is always below d, so the shifted value fits in WIDTH+2 bits.
    assign r_sh = (r << 2) | {{WIDTH{1'b0}}, bits};

    always_comb begin
        r_next  = r_sh;
        q_digit = 2'd0;
        if (r_sh >= d3) begin
            r_next  = r_sh - d3;
            q_digit = 2'd3;
        end else if (r_sh >= d2) begin
            r_next  = r_sh - d2;
            q_digit = 2'd2;
        end else if (r_sh >= d) begin
            r_next  = r_sh - d;
            q_digit = 2'd1;
        end
    end

endmodule

// File: rtl/div_radix4_seq.sv
// rtl/div_radix4_seq.sv - iterative radix-4 signed/unsigned divider with valid/ready
module div_radix4_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow,
    output logic             busy
);

    localparam int ITERS = WIDTH / 2;
    localparam int CNT_W = $clog2(ITERS);
    localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(min_s(WIDTH));
    localparam logic [WIDTH-1:0] ONES_V = WIDTH'(all_ones(WIDTH));
    localparam logic [WIDTH-1:0] DBZ_Q  = WIDTH'(dbz_quotient(WIDTH));

    div_state_t state, state_next;

    logic [WIDTH-1:0] dividend_l, divisor_l, a, q;
    logic             signed_l, neg_q, neg_r;
    logic [WIDTH+1:0] r, d, d2, d3, r_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       q_digit;

    logic             dvd_neg, dvs_neg, is_zero, is_ovf, last_iter;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign dvd_neg   = signed_l & dividend_l[WIDTH-1];
    assign dvs_neg   = signed_l & divisor_l[WIDTH-1];
    assign abs_a     = dvd_neg ? -dividend_l : dividend_l;
    assign abs_b     = dvs_neg ? -divisor_l : divisor_l;
    assign is_zero   = (divisor_l == '0);
    assign is_ovf    = signed_l && (dividend_l == MIN_V) && (divisor_l == ONES_V);
    assign last_iter = (cnt == CNT_W'(ITERS - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    div_radix4_step #(.WIDTH(WIDTH)) u_step (
        .r      (r),
        .d      (d),
        .d2     (d2),
        .d3     (d3),
        .bits   (a[WIDTH-1:WIDTH-2]),
        .r_next (r_next),
        .q_digit(q_digit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = PREP;
            PREP: state_next = (is_zero || is_ovf) ? DONE : ITER;
            ITER: if (last_iter) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dividend_l  <= '0;
            divisor_l   <= '0;
            signed_l    <= 1'b0;
            a           <= '0;
            q           <= '0;
            r           <= '0;
            d           <= '0;
            d2          <= '0;
            d3          <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    dividend_l  <= dividend;
                    divisor_l   <= divisor;
                    signed_l    <= is_signed;
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b0;
                end
                PREP: begin
                    a     <= abs_a;
                    d     <= {2'b00, abs_b};
                    d2    <= {1'b0, abs_b, 1'b0};
                    d3    <= {2'b00, abs_b} + {1'b0, abs_b, 1'b0};
                    neg_q <= dvd_neg ^ dvs_neg;
                    neg_r <= dvd_neg;
                    r     <= '0;
                    q     <= '0;
                    cnt   <= '0;
                    // Divide-by-zero wins over signed overflow.
                    if (is_zero) begin
                        quotient    <= DBZ_Q;
                        remainder   <= dividend_l;
                        div_by_zero <= 1'b1;
                    end else if (is_ovf) begin
                        quotient    <= MIN_V;
                        remainder   <= '0;
                        overflow    <= 1'b1;
                    end
                end
                ITER: begin
                    r   <= r_next;
                    q   <= {q[WIDTH-3:0], q_digit};
                    a   <= a << 2;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    quotient  <= neg_q ? -q : q;
                    remainder <= neg_r ? -r[WIDTH-1:0] : r[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_radix4_seq.sv
// tb/tb_div_radix4_seq.sv - self-checking bench for div_radix4_seq
module tb_div_radix4_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         is_signed = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] quotient, remainder;
    logic         div_by_zero, overflow, busy;

    int n_cmp = 0;
    int n_bad = 0;

    div_radix4_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .is_signed  (is_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain language-level division with the two special cases layered on top.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         output logic [W-1:0] eq, output logic [W-1:0] er,
                         output logic edz, output logic eov, output int elat);
        longint sa, sb;
        edz = 1'b0; eov = 1'b0; elat = W / 2 + 2;
        if (b == 0) begin
            eq = '1; er = a; edz = 1'b1; elat = 1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            eq = 32'h8000_0000; er = '0; eov = 1'b1; elat = 1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            eq = W'(sa / sb);
            er = W'(sa % sb);
        end else begin
            eq = a / b;
            er = a % b;
        end
    endtask

    // Issue one request, measure latency and check results; hold = cycles of out_ready=0.
    task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sgn, input int hold);
        logic [W-1:0] eq, er;
        logic edz, eov;
        int elat, n, lat;
        model(a, b, sgn, eq, er, edz, eov, elat);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check({tag, ".in_ready"}, in_ready, 1'b1);
        out_ready = (hold == 0);
        in_valid = 1'b1; dividend = a; divisor = b; is_signed = sgn;
        @(posedge clk); #1;
        in_valid = 1'b1;
        dividend = $urandom; divisor = $urandom; is_signed = $urandom_range(0, 1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
            if (lat == 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check({tag, ".latency"}, lat, elat);
        check({tag, ".quotient"}, quotient, eq);
        check({tag, ".remainder"}, remainder, er);
        check({tag, ".flags"}, {div_by_zero, overflow}, {edz, eov});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".bp_hold"}, {out_valid, in_ready, busy, quotient, remainder, div_by_zero, overflow},
                  {1'b1, 1'b0, 1'b1, eq, er, edz, eov});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ".release"}, {out_valid, in_ready, busy}, 3'b010);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic rs;
        #2;
        check("reset.ctrl", {in_ready, out_valid, busy}, 3'b100);
        check("reset.data", {quotient, remainder, div_by_zero, overflow}, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run("s10_3",   32'd10,          32'd3,          1'b1, 0);
        run("sm10_3",  -32'sd10,        32'd3,          1'b1, 0);
        run("s10_m2",  32'd10,          -32'sd2,        1'b1, 0);
        run("u_fff6",  32'hFFFF_FFF6,   32'd3,          1'b0, 0);
        run("s_fff6",  32'hFFFF_FFF6,   32'd3,          1'b1, 0);
        run("dz_s",    32'd10,          32'd0,          1'b1, 0);
        run("dz_u",    32'd10,          32'd0,          1'b0, 0);
        run("ovf_s",   32'h8000_0000,   32'hFFFF_FFFF,  1'b1, 0);
        run("ovf_u",   32'h8000_0000,   32'hFFFF_FFFF,  1'b0, 0);
        run("bp",      32'd1234567,     32'd89,         1'b0, 5);
        run("bp_next", -32'sd77,        32'd5,          1'b1, 0);
        run("maxu",    32'hFFFF_FFFF,   32'h0000_0001,  1'b0, 0);
        run("minmin",  32'h8000_0000,   32'h8000_0000,  1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = $urandom_range(1, 7);
                1: rb = 32'h0;
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: rb = -($urandom_range(1, 300));
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            rs = $urandom_range(0, 1);
            run("rand", ra, rb, rs, $urandom_range(0, 2));
        end

        // Abandon an operation mid-iteration with an asynchronous reset.
        in_valid = 1'b1; dividend = 32'd999; divisor = 32'd4; is_signed = 1'b0;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3; rst_n = 1'b0; #1;
        check("mid_rst.ctrl", {in_ready, out_valid, busy}, 3'b100);
        check("mid_rst.data", {quotient, remainder, div_by_zero, overflow}, '0);
        repeat (2) @(posedge clk);
        #3; rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rst.ready", {in_ready, out_valid, busy}, 3'b100);
        run("after_rst", 32'd100, 32'd7, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
